// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the data-memory access unit: operation codes,
// FSM state encoding and small decode helpers used by the top level and
// the lane alignment sub-module.
package mem_pkg;

   // Operation codes presented on req_op
   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LH  = 3'd1,
      OP_LHU = 3'd2,
      OP_LB  = 3'd3,
      OP_LBU = 3'd4,
      OP_SW  = 3'd5,
      OP_SH  = 3'd6,
      OP_SB  = 3'd7
   } op_e;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } state_e;

   // Stores occupy the top three codes
   function automatic logic is_store(input logic [2:0] op);
      return (op >= 3'd5);
   endfunction

   // Word ops need 4-byte alignment, half ops need 2-byte alignment
   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if ((op == OP_LW) || (op == OP_SW))
         mis = (off != 2'b00);
      else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
         mis = off[0];
      return mis;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
// Combinational byte-lane steering between a 32-bit memory word and the
// CPU side. Extracts and sign/zero-extends load data, and merges sub-word
// store data into the old word for read-modify-write.
// Ports:
//   op          operation code (mem_pkg op_e values)
//   byte_off    byte address bits [1:0]
//   old_word    word currently held in memory
//   store_data  low half of the store data (SB uses [7:0], SH uses [15:0])
//   load_data   extracted, extended load result
//   merged_word old_word with the addressed byte/half replaced
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  byte_off,
   input  logic [31:0] old_word,
   input  logic [15:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Pick the addressed lane; little-endian, byte k lives at bits [8k+7:8k]
   always_comb begin
      sel_byte = 8'd0;
      case (byte_off)
         2'd0:    sel_byte = old_word[7:0];
         2'd1:    sel_byte = old_word[15:8];
         2'd2:    sel_byte = old_word[23:16];
         default: sel_byte = old_word[31:24];
      endcase
      sel_half = byte_off[1] ? old_word[31:16] : old_word[15:0];
   end

   // Load extension by op
   always_comb begin
      load_data = old_word;
      case (op)
         OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
         OP_LBU:  load_data = {24'd0, sel_byte};
         OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
         OP_LHU:  load_data = {16'd0, sel_half};
         default: load_data = old_word;
      endcase
   end

   // Store merge: only the addressed lane changes, the rest of the word is kept
   always_comb begin
      merged_word = old_word;
      if (op == OP_SB) begin
         case (byte_off)
            2'd0:    merged_word[7:0]   = store_data[7:0];
            2'd1:    merged_word[15:8]  = store_data[7:0];
            2'd2:    merged_word[23:16] = store_data[7:0];
            default: merged_word[31:24] = store_data[7:0];
         endcase
      end else if (op == OP_SH) begin
         if (byte_off[1])
            merged_word[31:16] = store_data;
         else
            merged_word[15:0]  = store_data;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Initiator-side controller for the word-addressed data memory. Accepts
// load/store requests over valid/ready, checks alignment and range, drives
// the memory strobes and returns extended load data. SB/SH are performed
// as read-modify-write because the memory only stores whole words.
// Ports:
//   clock, reset_n            clock and asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_op/req_addr/req_wdata request fields (byte address)
//   resp_valid                one-cycle response pulse
//   resp_rdata/resp_error     response payload, zero outside RESP
//   mem_addr/mem_wdata        word index and write data to the memory
//   mem_read/mem_write        memory strobes, decoded from state only
//   mem_rdata                 combinational read data from the memory
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int MEM_SIZE = 10
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   state_e      state;
   logic [2:0]  op_q;
   logic [1:0]  off_q;
   logic [15:0] wdata_q;

   logic        accept;
   logic        req_bad;
   logic [31:0] load_data;
   logic [31:0] merged_word;

   // Handshake and strobes come straight from the state register so they
   // can never glitch or overlap
   assign req_ready  = (state == ST_IDLE);
   assign mem_read   = (state == ST_READ);
   assign mem_write  = (state == ST_WRITE);
   assign resp_valid = (state == ST_RESP);

   assign accept = req_valid && req_ready;

   // Any word index bit above MEM_SIZE means the access is past the end
   assign req_bad = is_misaligned(req_op, req_addr[1:0]) ||
                    ((req_addr[31:2] >> MEM_SIZE) != 30'd0);

   mem_lane_align u_lane (
      .op          (op_q),
      .byte_off    (off_q),
      .old_word    (mem_rdata),
      .store_data  (wdata_q),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // Controller FSM. Request fields are captured on acceptance so the
   // requester may change them immediately afterwards. Load data is
   // extended and registered at the end of the READ cycle; for SB/SH the
   // merged word is registered into mem_wdata for the following WRITE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         op_q       <= 3'd0;
         off_q      <= 2'd0;
         wdata_q    <= 16'd0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         resp_rdata <= 32'd0;
         resp_error <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q       <= req_op;
                  off_q      <= req_addr[1:0];
                  wdata_q    <= req_wdata[15:0];
                  mem_addr   <= {2'b00, req_addr[31:2]};
                  resp_rdata <= 32'd0;
                  if (req_bad) begin
                     resp_error <= 1'b1;
                     state      <= ST_RESP;
                  end else if (req_op == OP_SW) begin
                     mem_wdata <= req_wdata;
                     state     <= ST_WRITE;
                  end else begin
                     state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (is_store(op_q)) begin
                  mem_wdata <= merged_word;
                  state     <= ST_WRITE;
               end else begin
                  resp_rdata <= load_data;
                  state      <= ST_RESP;
               end
            end
            ST_WRITE: begin
               state <= ST_RESP;
            end
            ST_RESP: begin
               resp_rdata <= 32'd0;
               resp_error <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
